i2c_dbg_access_arbiter: RTL and testbench
=========================================

# i2c_dbg_access_arbiter

Round-robin arbiter and access sequencer for the I2C debug register port. It shares the single debug register interface (address, write data, write strobe, read data) between `NUM_REQ` requesters, such as the APB debug window, the JTAG bridge and the trigger/logging engine. For each granted access it generates the strobe/gap timing that the debug register block needs, and returns a one-cycle completion pulse with captured read data. It sits between the requesters and the debug register block, in the `i_sys_clk` domain.

## Interface
Parameters:
- `NUM_REQ`, 2: number of requesters; legal range 2..4.
- `WR_HOLD`, 2: cycles `o_dbg_write` is held high per write; legal range ≥1.
- `WR_GAP`, 4: cycles `o_dbg_write` is held low after the hold, before completion; legal range ≥1.
- `RD_WAIT`, 4: cycles the address is held before read data is captured; legal range ≥1.

Ports:
- `i_sys_clk` in 1: single clock.
- `i_rst_n` in 1: reset; synchronous, active-low.
- `i_req` in NUM_REQ: per-requester access request, level.
- `i_req_write` in NUM_REQ: 1 = write, 0 = read, per requester.
- `i_req_addr` in NUM_REQ*8: packed addresses; requester k uses bits [8k+7:8k].
- `i_req_wdata` in NUM_REQ*32: packed write data; requester k uses bits [32k+31:32k].
- `o_gnt` out NUM_REQ: one-hot grant, high for the whole service of the access.
- `o_done` out NUM_REQ: one-cycle completion pulse to the granted requester.
- `o_rdata` out 32: read data, valid in the `o_done` cycle; holds its value until the next read completes.
- `o_busy` out 1: high in any state other than IDLE.
- `o_dbg_addr` out 8: debug register address.
- `o_dbg_wdata` out 32: debug write data.
- `o_dbg_write` out 1: debug write strobe.
- `i_dbg_rdata` in 32: debug read data (combinational from the debug register block).

## Operation
- All outputs are registered. On reset, every output is 0 and the round-robin pointer is NUM_REQ-1, so requester 0 has the highest priority first.
- FSM states: IDLE, WR_HOLD_S, WR_GAP_S, RD_WAIT_S, DONE.
- **IDLE.**
  - With any `i_req` bit set, select the first set bit searching upward from pointer+1, modulo NUM_REQ.
  - Latch that requester's address, wdata and write flag into `o_dbg_addr` / `o_dbg_wdata`, and set `o_gnt[g]`.
  - Go to WR_HOLD_S with `o_dbg_write`=1 for a write, or to RD_WAIT_S for a read.
- **WR_HOLD_S.** Stay for WR_HOLD cycles, then clear `o_dbg_write` and go to WR_GAP_S.
- **WR_GAP_S.** Stay for WR_GAP cycles with the strobe low, then go to DONE.
- **RD_WAIT_S.** Stay for RD_WAIT cycles. On the edge leaving the state, capture `i_dbg_rdata` into `o_rdata`, then go to DONE.
- **DONE.**
  - `o_done[g]`=1 for exactly one cycle.
  - On exit, clear `o_gnt`, set pointer := g, and return to IDLE.
- A single down-counter, reloaded on every state entry and sized for max(WR_HOLD, WR_GAP, RD_WAIT), times all three wait states.
- `o_dbg_addr` and `o_dbg_wdata` are stable for the entire grant. After DONE they keep their last value; they are not cleared.
- Requesters hold `i_req` and their operands until `o_done`. Operands are latched at grant, so changes made after grant are ignored.
- If `i_req` drops mid-service, the access still completes and `o_done` still pulses.
- If `i_req` is still high in the cycle after `o_done`, that is a new access and it re-arbitrates normally.
- Non-granted requests wait. No pre-emption and no locking.

## Timing
- Request sampled in IDLE at edge E0: from E0, `o_gnt`, `o_busy` and `o_dbg_addr` / `o_dbg_wdata` are high or valid.
- **Write.**
  - `o_dbg_write` is high during cycles E0 .. E0+WR_HOLD-1.
  - It is low for the next WR_GAP cycles.
  - `o_done` is high in cycle E0+WR_HOLD+WR_GAP.
- **Read.**
  - `o_rdata` is captured at edge E0+RD_WAIT.
  - `o_done` is high in cycle E0+RD_WAIT.
- One IDLE cycle follows every DONE. Back-to-back throughput is WR_HOLD+WR_GAP+2 cycles per write and RD_WAIT+2 cycles per read.
- Requests arriving during service are considered only in IDLE, using the pointer as updated in DONE.
- Reset low at any edge, mid-operation included, returns the FSM to IDLE and all outputs to 0 at that edge. No `o_done` is issued for the aborted access.

## Test plan
- **Single write.** Defaults; req0 writes addr 0x00, data 0x0000000F. Expect `o_dbg_write` high for 2 cycles, low for 4, then `o_done[0]` in cycle E0+6; `o_dbg_addr`=0x00 throughout.
- **Single read.** req1 reads 0x14 with `i_dbg_rdata`=0x0000_3A5C. Expect `o_done[1]` at E0+4 with `o_rdata`=0x00003A5C; `o_dbg_write` never asserts.
- **Round-robin.** NUM_REQ=4, all four requests held continuously after reset. Expect grants in order 0,1,2,3,0; each `o_gnt` one-hot; no grant overlap.
- **Contention fairness.** req0 and req1 held continuously. Expect grants to alternate 0,1,0,1; one IDLE cycle between the DONE and the next grant.
- **Operand stability and early drop.** Change `i_req_addr` and drop `i_req` during WR_GAP_S. Expect `o_dbg_addr` unchanged and `o_done` still pulsing.
- **Reset mid-write.** Assert `i_rst_n`=0 during WR_HOLD_S. Expect all outputs 0 at the next edge and no `o_done`; after release, req0 again has priority.

Source files
------------

// File: rtl/i2c_dbg_access_arbiter.sv
// Round-robin arbiter and access sequencer sharing one debug register port
// between NUM_REQ requesters, with write strobe/gap and read-wait timing.
module i2c_dbg_access_arbiter #(
  parameter int unsigned NUM_REQ = 2,
  parameter int unsigned WR_HOLD = 2,
  parameter int unsigned WR_GAP  = 4,
  parameter int unsigned RD_WAIT = 4
) (
  input  logic                  i_sys_clk,
  input  logic                  i_rst_n,
  input  logic [NUM_REQ-1:0]    i_req,
  input  logic [NUM_REQ-1:0]    i_req_write,
  input  logic [NUM_REQ*8-1:0]  i_req_addr,
  input  logic [NUM_REQ*32-1:0] i_req_wdata,
  output logic [NUM_REQ-1:0]    o_gnt,
  output logic [NUM_REQ-1:0]    o_done,
  output logic [31:0]           o_rdata,
  output logic                  o_busy,
  output logic [7:0]            o_dbg_addr,
  output logic [31:0]           o_dbg_wdata,
  output logic                  o_dbg_write,
  input  logic [31:0]           i_dbg_rdata
);

  localparam int unsigned MAX_HG   = (WR_HOLD > WR_GAP) ? WR_HOLD : WR_GAP;
  localparam int unsigned MAX_WAIT = (MAX_HG > RD_WAIT) ? MAX_HG : RD_WAIT;
  localparam int unsigned CNT_W    = (MAX_WAIT > 1) ? $clog2(MAX_WAIT) : 1;
  localparam int unsigned PTR_W    = $clog2(NUM_REQ);

  typedef enum logic [2:0] {
    IDLE,
    WR_HOLD_S,
    WR_GAP_S,
    RD_WAIT_S,
    DONE
  } state_e;

  state_e             state_q, state_d;
  logic [CNT_W-1:0]   cnt_q, cnt_d;
  logic [PTR_W-1:0]   ptr_q, ptr_d;
  logic [PTR_W-1:0]   gidx_q, gidx_d;
  logic [NUM_REQ-1:0] gnt_q, gnt_d;
  logic [NUM_REQ-1:0] done_q, done_d;
  logic [31:0]        rdata_q, rdata_d;
  logic               busy_q, busy_d;
  logic [7:0]         addr_q, addr_d;
  logic [31:0]        wdata_q, wdata_d;
  logic               write_q, write_d;

  logic [PTR_W-1:0]   sel;
  logic [PTR_W-1:0]   cand;
  logic               sel_vld;

  // First requester searching upward from ptr+1, wrapping modulo NUM_REQ.
  always_comb begin
    sel_vld = 1'b0;
    sel     = '0;
    cand    = '0;
    for (int unsigned i = 1; i <= NUM_REQ; i++) begin
      cand = PTR_W'((32'(ptr_q) + i) % NUM_REQ);
      if (!sel_vld && i_req[cand]) begin
        sel_vld = 1'b1;
        sel     = cand;
      end
    end
  end

  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    ptr_d   = ptr_q;
    gidx_d  = gidx_q;
    gnt_d   = gnt_q;
    done_d  = '0;
    rdata_d = rdata_q;
    busy_d  = busy_q;
    addr_d  = addr_q;
    wdata_d = wdata_q;
    write_d = write_q;
    case (state_q)
      IDLE: begin
        if (sel_vld) begin
          gidx_d     = sel;
          gnt_d      = '0;
          gnt_d[sel] = 1'b1;
          busy_d     = 1'b1;
          addr_d     = i_req_addr[32'(sel)*8 +: 8];
          wdata_d    = i_req_wdata[32'(sel)*32 +: 32];
          if (i_req_write[sel]) begin
            state_d = WR_HOLD_S;
            write_d = 1'b1;
            cnt_d   = CNT_W'(WR_HOLD - 1);
          end else begin
            state_d = RD_WAIT_S;
            cnt_d   = CNT_W'(RD_WAIT - 1);
          end
        end
      end
      WR_HOLD_S: begin
        if (cnt_q == '0) begin
          state_d = WR_GAP_S;
          write_d = 1'b0;
          cnt_d   = CNT_W'(WR_GAP - 1);
        end else begin
          cnt_d = cnt_q - 1'b1;
        end
      end
      WR_GAP_S: begin
        if (cnt_q == '0) begin
          state_d = DONE;
          done_d  = gnt_q;
        end else begin
          cnt_d = cnt_q - 1'b1;
        end
      end
      RD_WAIT_S: begin
        if (cnt_q == '0) begin
          state_d = DONE;
          done_d  = gnt_q;
          rdata_d = i_dbg_rdata;
        end else begin
          cnt_d = cnt_q - 1'b1;
        end
      end
      DONE: begin
        state_d = IDLE;
        gnt_d   = '0;
        busy_d  = 1'b0;
        ptr_d   = gidx_q;
      end
      default: begin
        state_d = IDLE;
        gnt_d   = '0;
        busy_d  = 1'b0;
        write_d = 1'b0;
      end
    endcase
  end

  always_ff @(posedge i_sys_clk) begin
    if (!i_rst_n) begin
      state_q <= IDLE;
      cnt_q   <= '0;
      ptr_q   <= PTR_W'(NUM_REQ - 1);
      gidx_q  <= '0;
      gnt_q   <= '0;
      done_q  <= '0;
      rdata_q <= '0;
      busy_q  <= 1'b0;
      addr_q  <= '0;
      wdata_q <= '0;
      write_q <= 1'b0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      ptr_q   <= ptr_d;
      gidx_q  <= gidx_d;
      gnt_q   <= gnt_d;
      done_q  <= done_d;
      rdata_q <= rdata_d;
      busy_q  <= busy_d;
      addr_q  <= addr_d;
      wdata_q <= wdata_d;
      write_q <= write_d;
    end
  end

  assign o_gnt       = gnt_q;
  assign o_done      = done_q;
  assign o_rdata     = rdata_q;
  assign o_busy      = busy_q;
  assign o_dbg_addr  = addr_q;
  assign o_dbg_wdata = wdata_q;
  assign o_dbg_write = write_q;

endmodule

// File: tb/tb_i2c_dbg_access_arbiter.sv
// Scoreboard bench for i2c_dbg_access_arbiter: expected completions queued at
// drive time, popped and compared when o_done pulses.
module tb_i2c_dbg_access_arbiter;

  localparam int NR  = 4;
  localparam int WRH = 2;
  localparam int WRG = 4;
  localparam int RDW = 4;

  logic            clk = 1'b0;
  logic            rst_n;
  logic [NR-1:0]   req;
  logic [NR-1:0]   req_write;
  logic [NR*8-1:0] req_addr;
  logic [NR*32-1:0] req_wdata;
  logic [NR-1:0]   gnt;
  logic [NR-1:0]   done;
  logic [31:0]     rdata;
  logic            busy;
  logic [7:0]      dbg_addr;
  logic [31:0]     dbg_wdata;
  logic            dbg_write;
  logic [31:0]     dbg_rdata;
  logic [31:0]     age = '0;

  i2c_dbg_access_arbiter #(
    .NUM_REQ(NR),
    .WR_HOLD(WRH),
    .WR_GAP (WRG),
    .RD_WAIT(RDW)
  ) dut (
    .i_sys_clk  (clk),
    .i_rst_n    (rst_n),
    .i_req      (req),
    .i_req_write(req_write),
    .i_req_addr (req_addr),
    .i_req_wdata(req_wdata),
    .o_gnt      (gnt),
    .o_done     (done),
    .o_rdata    (rdata),
    .o_busy     (busy),
    .o_dbg_addr (dbg_addr),
    .o_dbg_wdata(dbg_wdata),
    .o_dbg_write(dbg_write),
    .i_dbg_rdata(dbg_rdata)
  );

  always #5 clk = ~clk;

  function automatic logic [31:0] rd_model(input logic [7:0] a);
    return 32'h0000_3A48 ^ {24'h0, a};
  endfunction

  // Debug block model: valid data only in the cycle before the capture edge.
  always @(posedge clk) age <= busy ? age + 32'd1 : 32'd0;
  assign dbg_rdata = (age == 32'(RDW - 1)) ? rd_model(dbg_addr) : (32'hDEAD_0000 | age);

  typedef struct {
    int          req;
    logic [7:0]  addr;
    logic [31:0] wdata;
    logic [31:0] rdata;
  } exp_t;

  exp_t        sb[$];
  logic [31:0] exp_last_rd = '0;
  int          n_chk = 0;
  int          n_err = 0;
  int          cyc = 0;
  int          last_done_cyc = -1;
  int          done_idx = -1;
  bit          chk_gap = 1'b0;
  logic [NR-1:0] prev_gnt = '0;

  task automatic chk(input string tag, input logic [63:0] act, input logic [63:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h", tag, act, exp);
    end
  endtask

  function automatic logic [63:0] oh(input int k);
    return 64'(1) << k;
  endfunction

  task automatic push_exp(input int k, input bit wr, input logic [7:0] a, input logic [31:0] d);
    exp_t e;
    e.req   = k;
    e.addr  = a;
    e.wdata = d;
    if (!wr) exp_last_rd = rd_model(a);
    e.rdata = exp_last_rd;
    sb.push_back(e);
  endtask

  task automatic set_req(input int k, input bit wr, input logic [7:0] a, input logic [31:0] d);
    req_addr[k*8 +: 8]    = a;
    req_wdata[k*32 +: 32] = d;
    req_write[k]          = wr;
    req[k]                = 1'b1;
  endtask

  // One negedge sample: structural invariants plus scoreboard pop on o_done.
  task automatic step();
    exp_t e;
    @(negedge clk);
    cyc++;
    done_idx = -1;
    for (int i = 0; i < NR; i++) if (done[i]) done_idx = i;
    chk("gnt_onehot0", 64'($onehot0(gnt)), 64'd1);
    chk("busy_vs_gnt", 64'(busy), 64'(gnt != '0));
    if (chk_gap && prev_gnt == '0 && gnt != '0 && last_done_cyc >= 0)
      chk("idle_gap", 64'(cyc - last_done_cyc), 64'd2);
    if (done != '0) begin
      last_done_cyc = cyc;
      if (sb.size() == 0) begin
        chk("unexpected_done", 64'(done), 64'd0);
      end else begin
        e = sb.pop_front();
        chk("sb_done", 64'(done), oh(e.req));
        chk("sb_gnt_at_done", 64'(gnt), 64'(done));
        chk("sb_addr", 64'(dbg_addr), 64'(e.addr));
        chk("sb_wdata", 64'(dbg_wdata), 64'(e.wdata));
        chk("sb_rdata", 64'(rdata), 64'(e.rdata));
      end
    end
    prev_gnt = gnt;
  endtask

  task automatic chk_all_zero(input string tag);
    chk({tag, "_gnt"}, 64'(gnt), 64'd0);
    chk({tag, "_done"}, 64'(done), 64'd0);
    chk({tag, "_rdata"}, 64'(rdata), 64'd0);
    chk({tag, "_busy"}, 64'(busy), 64'd0);
    chk({tag, "_addr"}, 64'(dbg_addr), 64'd0);
    chk({tag, "_wdata"}, 64'(dbg_wdata), 64'd0);
    chk({tag, "_write"}, 64'(dbg_write), 64'd0);
  endtask

  task automatic apply_reset(input string tag);
    req   = '0;
    rst_n = 1'b0;
    step();
    chk_all_zero(tag);
    step();
    step();
    sb.delete();
    exp_last_rd   = '0;
    last_done_cyc = -1;
    rst_n = 1'b1;
  endtask

  // Single access with cycle-exact checks; request dropped at sample drop_n.
  task automatic run_access(input int k, input bit wr, input logic [7:0] a,
                            input logic [31:0] d, input int drop_n);
    int len;
    len = wr ? (WRH + WRG) : RDW;
    set_req(k, wr, a, d);
    push_exp(k, wr, a, d);
    for (int n = 0; n <= len + 1; n++) begin
      step();
      if (n <= len) begin
        chk("acc_gnt", 64'(gnt), oh(k));
        chk("acc_busy", 64'(busy), 64'd1);
        chk("acc_addr", 64'(dbg_addr), 64'(a));
        chk("acc_wdata", 64'(dbg_wdata), 64'(d));
        chk("acc_write", 64'(dbg_write), 64'(wr && (n < WRH)));
        chk("acc_done", 64'(done), (n == len) ? oh(k) : 64'd0);
      end else begin
        chk("acc_idle", 64'(busy), 64'd0);
      end
      if (n == drop_n) begin
        req[k]                = 1'b0;
        req_addr[k*8 +: 8]    = ~a;
        req_wdata[k*32 +: 32] = ~d;
      end
    end
  endtask

  task automatic run_until_empty(input int budget, input bit drop_each);
    for (int i = 0; i < budget && sb.size() > 0; i++) begin
      step();
      if (drop_each && done_idx >= 0) req[done_idx] = 1'b0;
    end
    chk("sb_drained", 64'(sb.size()), 64'd0);
    req = '0;
  endtask

  initial begin
    #200000;
    $display("FAIL global_timeout: simulation did not finish");
    $fatal(1, "timeout");
  end

  initial begin
    rst_n     = 1'b0;
    req       = '0;
    req_write = '0;
    req_addr  = '0;
    req_wdata = '0;
    @(negedge clk);
    apply_reset("reset");

    // Single write, then single read.
    run_access(0, 1'b1, 8'h00, 32'h0000_000F, WRH + WRG);
    run_access(1, 1'b0, 8'h14, 32'h1111_2222, RDW);
    chk("read_value", 64'(rdata), 64'h3A5C);

    // Contention between 0 and 1, both held throughout.
    chk_gap = 1'b1;
    last_done_cyc = -1;
    set_req(0, 1'b1, 8'h20, 32'h55AA_0000);
    set_req(1, 1'b0, 8'h21, 32'h0BAD_F00D);
    push_exp(0, 1'b1, 8'h20, 32'h55AA_0000);
    push_exp(1, 1'b0, 8'h21, 32'h0BAD_F00D);
    push_exp(0, 1'b1, 8'h20, 32'h55AA_0000);
    push_exp(1, 1'b0, 8'h21, 32'h0BAD_F00D);
    run_until_empty(60, 1'b0);
    step();
    step();

    // Round-robin over four requesters from reset.
    apply_reset("reset2");
    for (int k = 0; k < NR; k++)
      set_req(k, k[0], 8'(8'h10 + k), 32'hA000_0000 | 32'(k));
    for (int j = 0; j < 5; j++)
      push_exp(j % NR, j[0], 8'(8'h10 + (j % NR)), 32'hA000_0000 | 32'(j % NR));
    run_until_empty(80, 1'b0);
    step();
    step();
    chk_gap = 1'b0;

    // Operand change and request drop during the write gap.
    run_access(2, 1'b1, 8'h33, 32'h1234_5678, WRH + 1);

    // Reset during write hold aborts the access; priority returns to 0.
    set_req(0, 1'b1, 8'h40, 32'hCAFE_0001);
    step();
    chk("rst_pre_gnt", 64'(gnt), oh(0));
    chk("rst_pre_write", 64'(dbg_write), 64'd1);
    sb.delete();
    apply_reset("reset_mid");
    chk_gap = 1'b1;
    set_req(3, 1'b0, 8'h43, 32'h0000_0033);
    set_req(0, 1'b1, 8'h41, 32'hCAFE_0002);
    push_exp(0, 1'b1, 8'h41, 32'hCAFE_0002);
    push_exp(3, 1'b0, 8'h43, 32'h0000_0033);
    run_until_empty(40, 1'b1);
    step();
    step();
    chk("final_idle", 64'(busy), 64'd0);

    $display("Result: errors=%0d of %0d checks", n_err, n_chk);
    $finish;
  end

endmodule
